// File: rtl/knight_cmd_pkg.sv
// knight_cmd_pkg: shared constants, opcodes and sequencer state type for the Knight command path
package knight_cmd_pkg;

    localparam logic [7:0] POS_ACK = 8'hA5;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_NAK   = 2'd1;
    localparam logic [1:0] ERR_TO    = 2'd2;
    localparam logic [1:0] ERR_EARLY = 2'd3;

    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [15:0] MOVE_N1  = 16'h4001;
    localparam logic [15:0] MOVE_N2  = 16'h4002;
    localparam logic [15:0] MOVE_N4  = 16'h4004;
    localparam logic [15:0] TOUR_GO  = 16'h6000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_NEXT,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/tour_cmd_sequencer.sv
// tour_cmd_sequencer: plays a stored list of commands to the UART transmitter, checking each for positive ack
module tour_cmd_sequencer
    import knight_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TO_W = 26,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [CW-1:0] num_cmds,
    input  logic          start,
    input  logic          abort,
    output logic [15:0]   cmd,
    output logic          snd_cmd,
    input  logic          cmd_snt,
    input  logic          resp_rdy,
    input  logic [7:0]    resp,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [CW-1:0] cmd_idx
);

    logic [15:0] mem [DEPTH];
    seq_state_t state, state_d;
    logic [CW-1:0] count, count_d, cmd_idx_d, n_clamp;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic [15:0] cmd_d;
    logic snd_d, done_d, err_d, timed_out;
    logic [1:0] code_d;

    always_ff @(posedge clk) begin
        if (wr_en && !busy) mem[wr_addr] <= wr_data;
    end

    assign timed_out = &to_cnt;
    assign n_clamp = (num_cmds > CW'(DEPTH)) ? CW'(DEPTH) : num_cmds;

    always_comb begin
        state_d = state;
        count_d = count;
        cmd_idx_d = cmd_idx;
        to_cnt_d = to_cnt;
        cmd_d = cmd;
        snd_d = 1'b0;
        done_d = 1'b0;
        err_d = err;
        code_d = err_code;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_d = 1'b0;
                        code_d = ERR_NONE;
                        cmd_idx_d = '0;
                        count_d = n_clamp;
                        done_d = (n_clamp == '0);
                        state_d = (n_clamp == '0) ? S_IDLE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cmd_d = mem[cmd_idx[AW-1:0]];
                    snd_d = 1'b1;
                    to_cnt_d = '0;
                    state_d = S_WAIT_SNT;
                end
                S_WAIT_SNT: begin
                    to_cnt_d = timed_out ? to_cnt : to_cnt + TO_W'(1);
                    // cmd_snt has priority; a coincident resp_rdy is dropped
                    if (cmd_snt) begin
                        state_d = S_WAIT_RESP;
                    end else if (resp_rdy || timed_out) begin
                        state_d = S_ERR;
                        code_d = resp_rdy ? ERR_EARLY : ERR_TO;
                    end
                end
                S_WAIT_RESP: begin
                    to_cnt_d = timed_out ? to_cnt : to_cnt + TO_W'(1);
                    if (resp_rdy) begin
                        state_d = (resp == POS_ACK) ? S_NEXT : S_ERR;
                        code_d = (resp == POS_ACK) ? err_code : ERR_NAK;
                    end else if (timed_out) begin
                        state_d = S_ERR;
                        code_d = ERR_TO;
                    end
                end
                S_NEXT: begin
                    cmd_idx_d = cmd_idx + CW'(1);
                    done_d = (cmd_idx_d == count);
                    state_d = done_d ? S_IDLE : S_ISSUE;
                end
                S_ERR: begin
                    err_d = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
            cmd_idx <= '0;
            to_cnt <= '0;
            cmd <= 16'h0000;
            snd_cmd <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state <= state_d;
            count <= count_d;
            cmd_idx <= cmd_idx_d;
            to_cnt <= to_cnt_d;
            cmd <= cmd_d;
            snd_cmd <= snd_d;
            busy <= (state_d != S_IDLE);
            done <= done_d;
            err <= err_d;
            err_code <= code_d;
        end
    end

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// tb_tour_cmd_sequencer: directed stimulus with a scoreboard of expected strobe/done/end events
module tb_tour_cmd_sequencer;

    localparam logic [3:0] K_SND = 4'd1;
    localparam logic [3:0] K_DONE = 4'd2;
    localparam logic [3:0] K_END = 4'd3;

    logic clk = 1'b0;
    logic rst_n;
    logic wr_en;
    logic [2:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0] num_cmds;
    logic start, abort, cmd_snt, resp_rdy;
    logic [7:0] resp;
    logic [15:0] cmd;
    logic snd_cmd, busy, done, err;
    logic [1:0] err_code;
    logic [3:0] cmd_idx;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];
    logic prev_busy = 1'b0;

    tour_cmd_sequencer #(.DEPTH(8), .TO_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_cmds(num_cmds), .start(start), .abort(abort), .cmd(cmd), .snd_cmd(snd_cmd),
        .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .cmd_idx(cmd_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ev(input logic [3:0] k, input logic [15:0] d, input logic [3:0] idx,
                                       input logic e, input logic [1:0] c, input logic b);
        return {k, d, idx, e, c, b, 4'h0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got %h expected none", got);
        end else begin
            check("scoreboard", got, exp_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_busy = 1'b0;
        end else begin
            if (snd_cmd) mon(ev(K_SND, cmd, 4'd0, 1'b0, 2'd0, 1'b0));
            if (done) mon(ev(K_DONE, 16'h0, cmd_idx, err, 2'd0, busy));
            else if (prev_busy && !busy) mon(ev(K_END, 16'h0, cmd_idx, err, err_code, 1'b0));
            prev_busy = busy;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [15:0] d);
        wr_en = 1'b1;
        wr_addr = a[2:0];
        wr_data = d;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic go(input int n);
        num_cmds = n[3:0];
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_snd();
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (snd_cmd) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_snd: got no snd_cmd expected strobe within 100 cycles");
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            tick(1);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=1 expected busy=0 within 200 cycles");
        end
        tick(2);
    endtask

    task automatic respond(input logic [7:0] r);
        tick(2);
        cmd_snt = 1'b1;
        tick(1);
        cmd_snt = 1'b0;
        tick(3);
        resp = r;
        resp_rdy = 1'b1;
        tick(1);
        resp_rdy = 1'b0;
    endtask

    task automatic play_ok(input int n);
        for (int i = 0; i < n; i++) begin
            wait_snd();
            respond(8'hA5);
        end
        wait_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        {wr_en, start, abort, cmd_snt, resp_rdy} = '0;
        wr_addr = '0;
        wr_data = '0;
        num_cmds = '0;
        resp = '0;
        tick(3);
        check("rst_cmd", {16'h0, cmd}, 32'h0);
        check("rst_flags", {27'h0, snd_cmd, busy, done, err, 1'b0}, 32'h0);
        check("rst_code_idx", {26'h0, err_code, cmd_idx}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // two commands, both acknowledged
        wr(0, 16'h2000);
        wr(1, 16'h4004);
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_SND, 16'h4004, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_DONE, 16'h0, 4'd2, 1'b0, 2'd0, 1'b0));
        go(2);
        check("busy_rise", {31'h0, busy}, 32'd1);
        check("snd_not_yet", {31'h0, snd_cmd}, 32'd0);
        play_ok(2);
        check("t1_idx", {28'h0, cmd_idx}, 32'd2);

        // zero commands: immediate done, never busy
        exp_q.push_back(ev(K_DONE, 16'h0, 4'd0, 1'b0, 2'd0, 1'b0));
        go(0);
        check("zero_busy", {31'h0, busy}, 32'd0);
        tick(2);
        check("zero_busy_after", {31'h0, busy}, 32'd0);

        // NAK on second response
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_SND, 16'h4004, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_END, 16'h0, 4'd1, 1'b1, 2'd1, 1'b0));
        go(2);
        wait_snd();
        respond(8'hA5);
        wait_snd();
        respond(8'h5A);
        wait_idle();
        check("nak_status", {26'h0, err, err_code, cmd_idx[2:0]}, {26'h0, 1'b1, 2'd1, 3'd1});

        // timeout with cmd_snt never arriving
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_END, 16'h0, 4'd0, 1'b1, 2'd2, 1'b0));
        go(1);
        wait_snd();
        check("start_clears_err", {31'h0, err}, 32'd0);
        n = 0;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        check("timeout_latency", n, 65);
        tick(2);

        // response before cmd_snt, then a clean replay
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_END, 16'h0, 4'd0, 1'b1, 2'd3, 1'b0));
        go(2);
        wait_snd();
        tick(1);
        resp = 8'hA5;
        resp_rdy = 1'b1;
        tick(1);
        resp_rdy = 1'b0;
        wait_idle();
        check("early_code", {30'h0, err_code}, 32'd3);
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_SND, 16'h4004, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_DONE, 16'h0, 4'd2, 1'b0, 2'd0, 1'b0));
        go(2);
        play_ok(2);

        // abort in WAIT_RESP, with writes attempted while busy
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_END, 16'h0, 4'd0, 1'b0, 2'd0, 1'b0));
        go(2);
        wait_snd();
        wr(0, 16'hDEAD);
        wr(1, 16'hBEEF);
        cmd_snt = 1'b1;
        tick(1);
        cmd_snt = 1'b0;
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_idle", {30'h0, busy, done}, 32'd0);
        wait_idle();
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_SND, 16'h4004, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_DONE, 16'h0, 4'd2, 1'b0, 2'd0, 1'b0));
        go(2);
        play_ok(2);

        // coincident cmd_snt and resp_rdy: the response is discarded
        exp_q.push_back(ev(K_SND, 16'h2000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_DONE, 16'h0, 4'd1, 1'b0, 2'd0, 1'b0));
        go(1);
        wait_snd();
        tick(2);
        resp = 8'h00;
        cmd_snt = 1'b1;
        resp_rdy = 1'b1;
        tick(1);
        cmd_snt = 1'b0;
        resp_rdy = 1'b0;
        tick(2);
        resp = 8'hA5;
        resp_rdy = 1'b1;
        tick(1);
        resp_rdy = 1'b0;
        wait_idle();

        // num_cmds beyond DEPTH clamps to DEPTH
        for (int i = 0; i < 8; i++) begin
            wr(i, 16'h4000 + 16'(i));
            exp_q.push_back(ev(K_SND, 16'h4000 + 16'(i), 4'd0, 1'b0, 2'd0, 1'b0));
        end
        exp_q.push_back(ev(K_DONE, 16'h0, 4'd8, 1'b0, 2'd0, 1'b0));
        go(9);
        play_ok(8);

        // reset in the middle of playback
        exp_q.push_back(ev(K_SND, 16'h4000, 4'd0, 1'b0, 2'd0, 1'b0));
        exp_q.push_back(ev(K_SND, 16'h4001, 4'd0, 1'b0, 2'd0, 1'b0));
        go(2);
        wait_snd();
        respond(8'hA5);
        wait_snd();
        tick(1);
        rst_n = 1'b0;
        #1;
        check("midrst_cmd", {16'h0, cmd}, 32'h0);
        check("midrst_status", {26'h0, busy, err, cmd_idx}, 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(3);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tour_cmd_sequencer.md
# tour_cmd_sequencer

- Upstream command player for the Knight: holds a small list of 16-bit commands (calibrate, move, tour) and issues them one at a time to the UART command transmitter.
- For each command it waits for transmit completion, then for the 8-bit response. It checks for positive acknowledge before advancing, with a per-command timeout.
- It sits between bench/host control logic and the remote-comm transmitter, and removes hand-sequenced send/ack handling from tour-level tests.

## Interface
Parameters:
- DEPTH, 8, number of command slots (power of 2, 2..16)
- TO_W, 26, timeout counter width; a timeout fires when the counter reaches all-ones

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write cmd slot (ignored while busy)
- wr_addr  in  $clog2(DEPTH)  slot index
- wr_data  in  16  command word
- num_cmds  in  $clog2(DEPTH)+1  commands to play, sampled on start
- start  in  1  begin playback from slot 0 (ignored while busy)
- abort  in  1  return to IDLE immediately
- cmd  out  16  command presented to transmitter
- snd_cmd  out  1  one-cycle send strobe
- cmd_snt  in  1  transmitter done pulse
- resp_rdy  in  1  response byte valid pulse
- resp  in  8  response byte
- busy  out  1  playback in progress
- done  out  1  one-cycle pulse, all commands acked
- err  out  1  sticky error, cleared by start
- err_code  out  2  1=NAK (resp≠8'hA5), 2=timeout, 3=response before cmd_snt
- cmd_idx  out  $clog2(DEPTH)+1  commands acked so far

## Operation
- Storage: DEPTH×16 register array, written synchronously on wr_en && !busy; not reset.
- States: IDLE, ISSUE, WAIT_SNT, WAIT_RESP, NEXT, ERR.
- IDLE → on start: clear err/err_code/cmd_idx, latch num_cmds. Go to ISSUE if num_cmds≠0, else pulse done and stay IDLE.
- ISSUE: load cmd from slot cmd_idx, pulse snd_cmd, clear timeout counter → WAIT_SNT.
- WAIT_SNT:
  - cmd_snt → WAIT_RESP.
  - resp_rdy first → ERR code 3.
  - Timeout → ERR code 2.
  - If cmd_snt and resp_rdy arrive in the same cycle, cmd_snt wins → WAIT_RESP, and the resp_rdy is lost.
- WAIT_RESP:
  - resp_rdy with resp==8'hA5 → NEXT.
  - resp_rdy with any other value → ERR code 1.
  - Timeout → ERR code 2.
- NEXT: cmd_idx+1. If equal to the latched count, pulse done → IDLE; else → ISSUE.
- ERR: set err, hold err_code and cmd_idx (index of failing command = cmd_idx), → IDLE.
- Timeout counter: runs only in WAIT_SNT/WAIT_RESP and saturates at all-ones; it is not shared between commands.
- abort: from any state → IDLE next cycle. No done pulse, err unchanged, no snd_cmd issued that cycle.
- num_cmds > DEPTH is clamped to DEPTH.

## Timing
- Reset values: cmd=16'h0000, snd_cmd=0, busy=0, done=0, err=0, err_code=0, cmd_idx=0, state=IDLE.
- All outputs are registered.
- busy=1 in every state except IDLE. It rises the cycle after start is accepted.
- snd_cmd rises 2 cycles after start (IDLE→ISSUE, then the strobe is registered).
- cmd is valid the same cycle as snd_cmd and held until the next ISSUE.
- Back-to-back: snd_cmd for the next command occurs 2 cycles after the accepted resp_rdy.
- done is asserted together with busy falling.
- Reset mid-playback: returns to IDLE at once, with all status cleared.

## Structure
- Shared package knight_cmd_pkg:
  - POS_ACK=8'hA5
  - seq_state_t enum
  - err code constants ERR_NAK/ERR_TO/ERR_EARLY
  - opcode constants CAL_GYRO=16'h2000, MOVE_N4=16'h4004, and their peers
- Single module; the timeout counter is inline. No sub-module is needed.

## Test plan
- Load {16'h2000, 16'h4004}, num_cmds=2, start; transmitter model returns A5 for each → two snd_cmd strobes with the correct cmd, done pulse, cmd_idx=2, err=0.
- num_cmds=0, start → done pulse 1 cycle later, no snd_cmd, busy stays 0.
- Second response = 8'h5A → err=1, err_code=1, cmd_idx=1, busy drops, no done.
- TO_W=6, cmd_snt never arrives → ERR after 63 cycles in WAIT_SNT, err_code=2.
- resp_rdy pulsed before cmd_snt → err_code=3; then a fresh start clears err and replays from slot 0.
- abort asserted during WAIT_RESP → IDLE next cycle, busy=0, no done. wr_en during busy leaves slot contents unchanged (verified on replay).
